// File: rtl/mem_uart_tx.sv
// Memory-to-UART dump: on start, reads NUM_WORDS bytes from address 0
// and sends each one as an 8N1 frame, LSB first.
module mem_uart_tx #(
    parameter int D_WIDTH      = 8,
    parameter int A_WIDTH      = 3,
    parameter int NUM_WORDS    = 4,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    output logic [A_WIDTH-1:0] raddr,
    output logic               ren,
    input  logic [D_WIDTH-1:0] rdata,
    output logic               tx,
    output logic               busy,
    output logic               done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
    localparam logic [CW-1:0]      BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]      BIT_LAST  = BW'(D_WIDTH - 1);
    localparam logic [A_WIDTH-1:0] IDX_LAST  = A_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, READ, LATCH, START_BIT, DATA, STOP_BIT
    } state_t;

    state_t             state, state_n;
    logic [CW-1:0]      baud, baud_n;
    logic [BW-1:0]      bit_cnt, bit_n;
    logic [A_WIDTH-1:0] idx, idx_n;
    logic [D_WIDTH-1:0] shift, shift_n;
    logic               tx_n, busy_n, done_n;
    logic               baud_end;

    assign raddr    = idx;
    assign ren      = (state == READ);
    assign baud_end = (baud == BAUD_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            idx     <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            idx     <= idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_cnt;
        idx_n   = idx;
        shift_n = shift;
        tx_n    = tx;
        busy_n  = busy;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                // a start coinciding with the done pulse is dropped
                if (start && !done) begin
                    state_n = READ;
                    busy_n  = 1'b1;
                    idx_n   = '0;
                    baud_n  = '0;
                end
            end
            READ: begin
                state_n = LATCH;
                baud_n  = '0;
            end
            LATCH: begin
                shift_n = rdata;
                tx_n    = 1'b0;
                baud_n  = '0;
                state_n = START_BIT;
            end
            START_BIT: begin
                if (baud_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    tx_n    = shift[0];
                    state_n = DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        tx_n    = 1'b1;
                        state_n = STOP_BIT;
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        shift_n = shift >> 1;
                        tx_n    = shift[1];
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            STOP_BIT: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (idx == IDX_LAST) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        idx_n   = '0;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = READ;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_uart_tx.sv
// Bench for mem_uart_tx: per-cycle comparison of tx/busy/done/ren/raddr
// against a waveform computed from frame arithmetic.
module tb_mem_uart_tx;

    localparam int CPB = 4;
    localparam int NW  = 4;
    localparam int P   = 10 * CPB + 2;
    localparam int T   = NW * P;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic [2:0] raddr;
    logic       ren;
    logic [7:0] rdata;
    logic       tx, busy, done;

    logic [7:0] mem [8];
    logic [7:0] exp_bytes [NW];

    int n_pass  = 0;
    int n_total = 0;

    mem_uart_tx #(
        .D_WIDTH(8),
        .A_WIDTH(3),
        .NUM_WORDS(NW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .start(start),
        .raddr(raddr),
        .ren(ren),
        .rdata(rdata),
        .tx(tx),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ren) rdata <= mem[raddr];
    end

    // {tx, busy, done, ren, raddr} expected k cycles after the start edge
    function automatic logic [6:0] exp_vec(input int k);
        int w, o, slot;
        logic t;
        if (k >= T)
            return {1'b1, 1'b0, (k == T), 1'b0, 3'd0};
        w = k / P;
        o = k % P;
        if (o < 2) begin
            t = 1'b1;
        end else begin
            slot = (o - 2) / CPB;
            if (slot == 0)      t = 1'b0;
            else if (slot <= 8) t = exp_bytes[w][slot-1];
            else                t = 1'b1;
        end
        return {t, 1'b1, 1'b0, (o == 0), 3'(w)};
    endfunction

    function automatic logic [6:0] obs_vec();
        return {tx, busy, done, ren, raddr};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the sample point right after the start edge.
    task automatic run_dump(input string name, input int mid_k,
                            input bit on_done, input bit chain,
                            input int abort_k, input int wr_k);
        int last;
        logic [6:0] e, o;
        last = chain ? T + 1 : T + 4;
        for (int i = 0; i < NW; i++) exp_bytes[i] = mem[i];
        for (int k = 0; k <= last; k++) begin
            if (k == abort_k) break;
            if (k == wr_k) begin
                mem[0] = ~mem[0];
                mem[3] = 8'($urandom);
                exp_bytes[3] = mem[3];
            end
            e = exp_vec(k);
            o = obs_vec();
            n_total++;
            if (o !== e)
                $display("FAIL %s k=%0d {tx,busy,done,ren,raddr} got %b want %b",
                         name, k, o, e);
            else
                n_pass++;
            start = (k == mid_k) || (on_done && k == T) || (chain && k == last);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (obs_vec() !== 7'b1000000)
            $display("FAIL reset got %b want %b", obs_vec(), 7'b1000000);
        else
            n_pass++;
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec() !== 7'b1000000)
                $display("FAIL idle_hold i=%0d got %b want %b",
                         i, obs_vec(), 7'b1000000);
            else
                n_pass++;
        end
    endtask

    task automatic test_full_dump();
        mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43; mem[3] = 8'h44;
        pulse_start();
        run_dump("dump", -1, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_ignore_start();
        pulse_start();
        run_dump("ignore", 50, 1'b1, 1'b1, -1, -1);
        run_dump("restart", -1, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_async_reset();
        pulse_start();
        run_dump("pre_rst", -1, 1'b0, 1'b0, 2 * P + 2 + 4 * CPB + 1, -1);
        #1 n_rst = 1'b0;
        #1;
        n_total++;
        if (obs_vec() !== 7'b1000000)
            $display("FAIL async_rst got %b want %b", obs_vec(), 7'b1000000);
        else
            n_pass++;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start();
        run_dump("resend", -1, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_ff_zero();
        mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'hFF; mem[3] = 8'h00;
        pulse_start();
        run_dump("ff_zero", -1, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            pulse_start();
            run_dump("random", -1, 1'b0, 1'b0, -1, P + 5);
        end
    endtask

    initial begin
        start = 1'b0;
        n_rst = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        test_reset();
        test_full_dump();
        test_ignore_start();
        test_async_reset();
        test_ff_zero();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_uart_tx.md
Name: mem_uart_tx

Overview:
Read-side counterpart of the UART-RX-to-memory write path. On a start pulse (e.g. debounced push switch) it reads NUM_WORDS bytes from the shared dual-port memory, starting at address 0. It serializes each byte onto a UART TX line as 8N1, LSB first, at a fixed baud divisor. It sits between the memory read port and the board UART TX pin, and includes its own baud counter and serializer.

Parameters:
D_WIDTH, 8, memory data width and UART data bits per frame
A_WIDTH, 3, memory address width
NUM_WORDS, 4, bytes sent per start; legal range 1..2^A_WIDTH
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200)

Ports:
clk  input  1  system clock, all logic on rising edge
n_rst  input  1  asynchronous active-low reset
start  input  1  synchronous, sampled each clk; one-cycle pulse requests a dump
raddr  output  A_WIDTH  memory read address
ren  output  1  memory read enable
rdata  input  D_WIDTH  memory read data, valid the cycle after ren (registered memory)
tx  output  1  UART serial out, idle high
busy  output  1  high from start acceptance until the last stop bit completes
done  output  1  one-cycle pulse after the final stop bit of a dump

Behaviour:
- Reset (asynchronous, effective immediately, including mid-frame): state=IDLE, tx=1, busy=0, done=0, ren=0, raddr=0, word index=0, bit and baud counters=0, shift register=0.
- All outputs are registered except ren. ren is decoded from state: ren=1 only in READ.
- raddr equals the word index (zero-extended, truncated to A_WIDTH).
- FSM states: IDLE, READ, LATCH, START_BIT, DATA, STOP_BIT.
- IDLE:
  - tx=1, busy=0.
  - start=1 at edge E0 → READ, busy<=1, word index=0.
  - start=0 → stay in IDLE.
- READ: lasts one cycle with ren=1, raddr=index → LATCH.
- LATCH: one cycle. At the exit edge, shift<=rdata and tx<=0 → START_BIT. The first start-bit falling edge of tx therefore occurs at E0+2 cycles.
- START_BIT: tx=0 for exactly CLKS_PER_BIT cycles, then tx<=shift[0] → DATA with bit counter=0.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles; the line is driven LSB first.
  - After bit D_WIDTH-1, tx<=1 → STOP_BIT.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles, then:
  - index < NUM_WORDS-1 → index+1, go to READ. The inter-frame gap is the stop bit plus 2 cycles of tx=1.
  - index == NUM_WORDS-1 → IDLE, busy<=0, done<=1 for exactly one cycle, index and raddr <=0.
- Frame length is (D_WIDTH+2)*CLKS_PER_BIT cycles.
- Total dump time from E0 to the done edge is NUM_WORDS*((D_WIDTH+2)*CLKS_PER_BIT+2) cycles.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - Cleared on every state entry.
- start while busy=1 (including on the done cycle) is ignored; there is no queuing. start in the cycle after done starts a new dump.
- rdata is sampled only in LATCH. Memory writes during a dump affect only words not yet latched.
- NUM_WORDS=1: a single frame, then done.

Test Plan:
- Reset with CLKS_PER_BIT=4, memory preloaded 0x41,0x42,0x43,0x44: check tx=1, busy=0, done=0, ren=0, raddr=0 → hold tx=1 indefinitely with start=0.
- Pulse start → ren=1 with raddr=0 on the next cycle. tx falls 2 cycles after start is sampled. The line carries 0,1,0,0,0,0,0,1,0,1 (0x41), each bit 4 cycles.
- Full dump → frames 0x41,0x42,0x43,0x44 in order. raddr steps 0,1,2,3, with exactly one ren pulse per word. done pulses once at cycle 4*(40+2)=168 after start, and busy falls on the same edge.
- start pulsed mid-frame and on the done cycle → no extra frames and no restart. start one cycle after done → a new dump from address 0.
- Assert n_rst during data bit 3 of frame 2 → tx=1 immediately (asynchronous), busy=0. A subsequent start resends from 0x41.
- Byte 0xFF with a 0x00 neighbour → bit timing is exactly CLKS_PER_BIT with no glitches, and a valid stop bit precedes the next start bit (gap = 4+2 cycles high).
